// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes for the multiply/divide unit and the divider state encoding.
package alu_ctrl_pkg;

    localparam logic [5:0] MULTU     = 6'b011001;
    localparam logic [5:0] MADDU     = 6'b000001;
    localparam logic [5:0] MULTU_out = 6'b111111;
    localparam logic [5:0] MADDU_out = 6'b111110;
    localparam logic [5:0] DIVU      = 6'b011011;
    localparam logic [5:0] DIVU_out  = 6'b111101;
    localparam logic [5:0] DIV       = 6'b011010;
    localparam logic [5:0] DIV_out   = 6'b111100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/divu_step.sv
// One restoring shift-subtract iteration of the divider (purely combinational).
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           take;

    always_comb begin
        rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, div};
        // A bit shifted out of REM means the partial remainder certainly exceeds DIV.
        take   = ~trial[WIDTH] | rem[WIDTH];
        if (take) begin
            rem_next = trial;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh;
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divu.sv
// Iterative restoring divider delivering {remainder, quotient} on read-out.
// Optional signed DIV/DIV_out support is enabled by defining DIVU_SIGNED_EN.
module divu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 busy,
    output logic                 done,
    output logic                 dz
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_next;
    logic [WIDTH:0]   rem, rem_step;
    logic [WIDTH-1:0] quo, quo_step;
    logic [WIDTH-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic             start;
    logic             start_signed;
    logic             read_out;
    logic             fix_needed;

`ifdef DIVU_SIGNED_EN
    logic signed_op, neg_q, neg_r;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign start_signed = (Signal == DIV);
    assign read_out     = (Signal == DIVU_out) || (Signal == DIV_out);
    assign fix_needed   = signed_op;
`else
    assign start_signed = 1'b0;
    assign read_out     = (Signal == DIVU_out);
    assign fix_needed   = 1'b0;
`endif

    assign start     = (Signal == DIVU) || start_signed;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state == BUSY) || (state == FIXUP);
    assign done      = (state == DONE);

    divu_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .div      (div),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last_step) state_next = fix_needed ? FIXUP : DONE;
            FIXUP:   state_next = DONE;
            DONE:    if (read_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem     <= '0;
            quo     <= '0;
            div     <= '0;
            cnt     <= '0;
            dz      <= 1'b0;
            dataOut <= '0;
`ifdef DIVU_SIGNED_EN
            signed_op <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem <= '0;
                        cnt <= '0;
                        dz  <= (dataB == '0);
`ifdef DIVU_SIGNED_EN
                        quo       <= start_signed ? mag(dataA) : dataA;
                        div       <= start_signed ? mag(dataB) : dataB;
                        signed_op <= start_signed;
                        neg_q     <= start_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        neg_r     <= start_signed & dataA[WIDTH-1];
`else
                        quo <= dataA;
                        div <= dataB;
`endif
                    end
                end
                BUSY: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                end
`ifdef DIVU_SIGNED_EN
                FIXUP: begin
                    if (neg_q) quo <= -quo;
                    if (neg_r) rem <= {1'b0, -rem[WIDTH-1:0]};
                end
`endif
                DONE: begin
                    if (read_out) dataOut <= {rem[WIDTH-1:0], quo};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/divu.md
# divu

Iterative 32-bit unsigned divider for the MIPS pipeline's multiply/divide unit, the inverse partner of the shift-add unsigned multiplier. Operates under the same 6-bit ALU control `Signal` codes. On a DIVU code it latches both operands and runs one restoring shift-subtract step per clock. On a read-out code it delivers `{remainder, quotient}` as a 64-bit HI/LO word.

## Interface
- `WIDTH`, default 32: operand width; `dataOut` is 2*WIDTH.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `dataA` input 32: dividend; sampled only when a divide starts.
- `dataB` input 32: divisor; sampled only when a divide starts.
- `Signal` input 6: ALU control code.
- `dataOut` output 64: `{remainder[63:32], quotient[31:0]}`; updated only on read-out.
- `busy` output 1: high while iterating.
- `done` output 1: high when a result is waiting for read-out.
- `dz` output 1: divide-by-zero flag for the pending or last-read result.

## Operation
- Control codes: DIVU = 6'b011011 (27), DIVU_out = 6'b111101. All other codes are ignored.
- States:
  - IDLE: DIVU latches `dataA` into QUO and `dataB` into DIV, clears REM (33-bit), sets cnt=0 and `dz=(dataB==0)`, then goes to BUSY.
  - BUSY: one step per edge, independent of `Signal`:
    - `{REM,QUO} <<= 1`
    - `trial = REM - {1'b0,DIV}`
    - if `trial[32]==0`: REM=trial, QUO[0]=1; else QUO[0]=0
    - cnt++
    - after step 32, go to DONE.
  - DONE: DIVU_out loads `dataOut={REM[31:0],QUO}` and goes to IDLE. `dz` holds until the next DIVU start.
- Ignored inputs:
  - DIVU while BUSY or DONE is ignored; no restart, and the operands are not resampled.
  - DIVU_out in IDLE or BUSY is ignored; `dataOut` keeps its old value.
- Divide by zero: no special datapath. The algorithm naturally yields quotient 0xFFFFFFFF and remainder = dividend; `dz`=1.
- Widths: REM is 33 bits, so the trial subtraction sign is bit 32. The quotient is exact floor; remainder < divisor when the divisor ≠ 0.

## Timing
- Reset values: `dataOut`=0, `busy`=0, `done`=0, `dz`=0, state IDLE, REM/QUO/DIV/cnt=0.
- Edge E0 samples DIVU in IDLE, and `busy` rises after E0.
- Steps execute on E1..E32. `busy` falls and `done` rises after E32, so latency is 32 cycles from start to `done`.
- DIVU_out sampled at an edge with `done`=1: `dataOut` valid and `done` low after that edge. A new DIVU is accepted at the next edge at the earliest.
- Reset asserted mid-operation aborts immediately: all outputs return to their reset values and the pending result is lost.
- Minimum start-to-start period: 34 cycles.

## Configuration
- `DIVU_SIGNED_EN` defined:
  - Adds DIV = 6'b011010 (26) and DIV_out = 6'b111100.
  - DIV latches |dataA| and |dataB| and records both signs.
  - Adds a FIXUP state after step 32:
    - quotient negated if the signs differ
    - remainder takes the dividend's sign
  - Signed latency is 33 cycles.
  - Divide-by-zero still sets `dz`; the values are the magnitude result with fixup applied.
- `DIVU_SIGNED_EN` undefined: codes 26 and 6'b111100 are ignored like any other code, and there is no FIXUP state.

## Structure
- Shared package `alu_ctrl_pkg`:
  - all `Signal` code constants (MULTU, MADDU, MULTU_out, MADDU_out, DIVU, DIVU_out, DIV, DIV_out)
  - the divider state enum (IDLE, BUSY, FIXUP, DONE)
- One sub-module, `divu_step`: combinational single iteration. Takes REM, QUO and DIV; returns the next REM and QUO.

## Test plan
- 100 / 7 via DIVU, wait `done`, then DIVU_out → `dataOut`={32'd2, 32'd14}; `done` rises exactly 32 cycles after the start edge.
- 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0. Then 5 / 9 → quotient 0, remainder 5.
- 1234 / 0 → `dz`=1, `dataOut`={32'd1234, 32'hFFFFFFFF}.
- Start 1000/3, and at cycle 10:
  - issue DIVU_out → ignored
  - issue DIVU with new operands → ignored
  - final read-out → {1, 333}
- Pull `reset` low at cycle 15 of a divide → all outputs 0 immediately. A fresh 50/5 afterwards → {0, 10}.
- `DIVU_SIGNED_EN`: DIV -7/2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1), `done` at 33 cycles. The same codes without the macro → `busy` never rises.
